// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC sequencing, credit-limited memory requests and an output FIFO.
// Optional FETCH_BYPASS_EN presents a kept response to decode in its arrival cycle.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemReqAddr,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic        outValid,
  input  logic        outStall,
  output logic [31:0] outPc,
  output logic [31:0] outInstr,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW:0] CREDITS = DEPTH[CW:0];

  logic [31:0]   pc_q;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   issued_pc  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, issued_rd, issued_wr;
  logic [CW-1:0] fifo_count, inflight, drop_cnt;

  logic          accept, resp_keep, bypass, push, pop, fifo_empty;
  logic [31:0]   resp_pc;
  logic [CW:0]   credit_used;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirectPc[1:0];

  assign credit_used  = {1'b0, fifo_count} + {1'b0, inflight};
  assign imemReqValid = !rst && !redirectValid && (credit_used < CREDITS);
  assign imemReqAddr  = pc_q;
  assign accept       = imemReqValid && imemReqReady;

  assign fifo_empty = (fifo_count == '0);
  assign resp_pc    = issued_pc[issued_rd];
  assign resp_keep  = imemRespValid && (drop_cnt == '0) && !redirectValid;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep && fifo_empty && !outStall;
`else
  assign bypass = 1'b0;
`endif

  assign push     = resp_keep && !bypass;
  assign outValid = !rst && !redirectValid && (!fifo_empty || bypass);
  assign pop      = outValid && !outStall && !fifo_empty;

  // Outputs read as zero whenever nothing is presented.
  always_comb begin
    outPc    = '0;
    outInstr = '0;
    if (outValid) begin
      if (!fifo_empty) begin
        outPc    = fifo_pc[rd_ptr];
        outInstr = fifo_instr[rd_ptr];
      end
`ifdef FETCH_BYPASS_EN
      else begin
        outPc    = resp_pc;
        outInstr = imemRespData;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      issued_rd  <= '0;
      issued_wr  <= '0;
      fifo_count <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
    end else begin
      if (accept) begin
        issued_wr <= issued_wr + AW'(1);
      end
      if (imemRespValid) begin
        issued_rd <= issued_rd + AW'(1);
      end
      inflight <= inflight + CW'(accept) - CW'(imemRespValid);

      if (redirectValid) begin
        pc_q       <= {redirectPc[31:2], 2'b00};
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
        // Every request still outstanding after this cycle is stale, including ones
        // already counted in drop_cnt, so the new count is simply what remains in flight.
        drop_cnt   <= inflight - CW'(imemRespValid);
      end else begin
        if (accept) begin
          pc_q <= pc_q + 32'd4;
        end
        if (imemRespValid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      issued_pc[issued_wr] <= pc_q;
    end
    if (!rst && !redirectValid && push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= imemRespData;
    end
  end

endmodule
